mux_2_1: RTL and testbench

MUX_2_1 -- requirements
Module: mux_2_1

---
 rtl/mux_pkg.sv | 14 +
 rtl/mux_2_1_if.sv | 37 +++
 rtl/dff_sync_rst.sv | 32 +++
 rtl/mux_2_1.sv | 54 +++++
 tb/tb_mux_2_1.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mux_pkg.sv
// ---------------------------------------------------------------------------
// mux_pkg
// Shared constants for the 2:1 multiplexer slice.
//   SEL_IN_1      : select value that routes in_1 to out
//   SEL_IN_2      : select value that routes in_2 to out
//   DEFAULT_WIDTH : data width used when no WIDTH override is given
// ---------------------------------------------------------------------------
package mux_pkg;

   localparam int   DEFAULT_WIDTH = 1;
   localparam logic SEL_IN_1      = 1'b0;
   localparam logic SEL_IN_2      = 1'b1;

endpackage

// File: rtl/mux_2_1_if.sv
// ---------------------------------------------------------------------------
// mux_2_1_if
// Data/select bundle between a source and the 2:1 multiplexer.
//   in_1  [WIDTH] : data routed to out when sel == SEL_IN_1
//   in_2  [WIDTH] : data routed to out when sel == SEL_IN_2
//   sel   [1]     : source select
//   out   [WIDTH] : selected data
// Modports:
//   master : drives in_1/in_2/sel, observes out
//   slave  : the multiplexer side, receives in_1/in_2/sel, drives out
// ---------------------------------------------------------------------------
interface mux_2_1_if
   import mux_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic [WIDTH-1:0] in_1;
   logic [WIDTH-1:0] in_2;
   logic             sel;
   logic [WIDTH-1:0] out;

   modport master (
      output in_1,
      output in_2,
      output sel,
      input  out
   );

   modport slave (
      input  in_1,
      input  in_2,
      input  sel,
      output out
   );

endinterface

// File: rtl/dff_sync_rst.sv
// ---------------------------------------------------------------------------
// dff_sync_rst
// WIDTH-bit rising-edge register with synchronous, active-high reset to zero.
//   i_clk         : clock
//   i_rst         : synchronous active-high reset, clears o_q at the edge
//   i_d   [WIDTH] : data captured at each rising edge
//   o_q   [WIDTH] : registered data, driven straight from the flops
// ---------------------------------------------------------------------------
module dff_sync_rst #(
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // Reset wins over the data path; it is only looked at on the clock edge,
   // so a pulse between edges never disturbs the stored value.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_q <= '0;
      end else begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/mux_2_1.sv
// ---------------------------------------------------------------------------
// mux_2_1
// 2:1 data multiplexer with optional output register.
// Parameters:
//   WIDTH   : data width of in_1, in_2 and out (1..64)
//   OUT_REG : 1 = out registered (1-cycle latency), 0 = out combinational
// Ports:
//   sys_clk : single clock, rising-edge
//   sys_rst : synchronous active-high reset (registered variant only)
//   bus     : mux_2_1_if slave (in_1, in_2, sel in; out out)
// ---------------------------------------------------------------------------
module mux_2_1
   import mux_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int OUT_REG = 1
) (
   input  logic      sys_clk,
   input  logic      sys_rst,
   mux_2_1_if.slave  bus
);

   logic [WIDTH-1:0] w_nextOut;

   // One selection expression feeds both output variants, so the registered
   // and combinational builds can never disagree on which input is chosen.
   assign w_nextOut = (bus.sel == SEL_IN_2) ? bus.in_2 : bus.in_1;

   // The registered build drives out directly from flops, which keeps it
   // glitch-free between edges; the combinational build passes the
   // selection straight through and ignores clock and reset entirely.
   generate
      if (OUT_REG != 0) begin : g_outReg
         logic [WIDTH-1:0] w_regOut;

         dff_sync_rst #(
            .WIDTH (WIDTH)
         ) u_outReg (
            .i_clk (sys_clk),
            .i_rst (sys_rst),
            .i_d   (w_nextOut),
            .o_q   (w_regOut)
         );

         assign bus.out = w_regOut;
      end else begin : g_outComb
         logic w_unusedClkRst;

         assign w_unusedClkRst = sys_clk ^ sys_rst;
         assign bus.out        = w_nextOut;
      end
   endgenerate

endmodule

// File: tb/tb_mux_2_1.sv
// ---------------------------------------------------------------------------
// tb_mux_2_1
// Self-checking bench for mux_2_1. Three instances share one clock/reset:
//   dutReg  : WIDTH=1, OUT_REG=1
//   dutComb : WIDTH=1, OUT_REG=0
//   dutWide : WIDTH=8, OUT_REG=1
// Inputs change on the falling edge; registered outputs are sampled 1 ns
// after the rising edge, combinational outputs 1 ns after the inputs move.
// ---------------------------------------------------------------------------
module tb_mux_2_1;
   import mux_pkg::*;

   logic sysClk = 1'b0;
   logic sysRst = 1'b1;

   int checks   = 0;
   int failures = 0;

   // Reference model state: what the registered output must show after the
   // next rising edge, derived from the values sitting on the inputs.
   logic       expReg;
   logic       expComb;
   logic [7:0] expWide;

   always #5 sysClk = ~sysClk;

   mux_2_1_if #(.WIDTH(1)) regBus ();
   mux_2_1_if #(.WIDTH(1)) combBus ();
   mux_2_1_if #(.WIDTH(8)) wideBus ();

   mux_2_1 #(.WIDTH(1), .OUT_REG(1)) dutReg (
      .sys_clk (sysClk),
      .sys_rst (sysRst),
      .bus     (regBus)
   );

   mux_2_1 #(.WIDTH(1), .OUT_REG(0)) dutComb (
      .sys_clk (sysClk),
      .sys_rst (sysRst),
      .bus     (combBus)
   );

   mux_2_1 #(.WIDTH(8), .OUT_REG(1)) dutWide (
      .sys_clk (sysClk),
      .sys_rst (sysRst),
      .bus     (wideBus)
   );

   // Reference selection: the chosen source is looked up by select value in
   // a two-entry table, and reset simply replaces the result with zero.
   function automatic logic [63:0] refSelect(input logic [63:0] a,
                                             input logic [63:0] b,
                                             input logic        s,
                                             input logic        rst);
      logic [63:0] table2 [2];
      table2[0] = a;
      table2[1] = b;
      return rst ? 64'd0 : table2[s];
   endfunction

   // Drive the 1-bit instances identically and refresh their expectations.
   task automatic applyStimulus(input logic a, input logic b,
                                input logic s, input logic rst);
      regBus.in_1  = a;
      regBus.in_2  = b;
      regBus.sel   = s;
      combBus.in_1 = a;
      combBus.in_2 = b;
      combBus.sel  = s;
      sysRst       = rst;
      expReg  = refSelect({63'd0, a}, {63'd0, b}, s, rst)   != 64'd0;
      expComb = refSelect({63'd0, a}, {63'd0, b}, s, 1'b0)  != 64'd0;
   endtask

   task automatic applyWide(input logic [7:0] a, input logic [7:0] b,
                            input logic s, input logic rst);
      wideBus.in_1 = a;
      wideBus.in_2 = b;
      wideBus.sel  = s;
      sysRst       = rst;
      expWide = refSelect({56'd0, a}, {56'd0, b}, s, rst) & 64'hFF;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic nextEdge();
      @(posedge sysClk);
      #1;
   endtask

   initial begin
      logic a;
      logic b;
      logic s;
      logic r;

      $display("[TB] start");
      applyWide(8'h00, 8'h00, 1'b0, 1'b1);

      // Reset held for two edges with every input high.
      @(negedge sysClk);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
      nextEdge();
      checkOutput("reset_edge1", {63'd0, regBus.out}, 64'd0);
      checkOutput("reset_comb_ignores_rst", {63'd0, combBus.out}, 64'd1);
      nextEdge();
      checkOutput("reset_edge2", {63'd0, regBus.out}, 64'd0);
      checkOutput("reset_wide", {56'd0, wideBus.out}, 64'd0);
      @(negedge sysClk);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
      nextEdge();
      checkOutput("reset_release", {63'd0, regBus.out}, 64'd1);

      // Select in_1, then change in_1.
      @(negedge sysClk);
      applyStimulus(1'b1, 1'b0, SEL_IN_1, 1'b0);
      nextEdge();
      checkOutput("sel_in1_one", {63'd0, regBus.out}, 64'd1);
      @(negedge sysClk);
      applyStimulus(1'b0, 1'b0, SEL_IN_1, 1'b0);
      nextEdge();
      checkOutput("sel_in1_zero", {63'd0, regBus.out}, 64'd0);

      // Select in_2, then flip select back to in_1.
      @(negedge sysClk);
      applyStimulus(1'b0, 1'b1, SEL_IN_2, 1'b0);
      #1;
      checkOutput("comb_sel_in2", {63'd0, combBus.out}, 64'd1);
      nextEdge();
      checkOutput("sel_in2_one", {63'd0, regBus.out}, 64'd1);
      @(negedge sysClk);
      applyStimulus(1'b0, 1'b1, SEL_IN_1, 1'b0);
      #1;
      checkOutput("comb_sel_toggle", {63'd0, combBus.out}, 64'd0);
      nextEdge();
      checkOutput("sel_toggle_zero", {63'd0, regBus.out}, 64'd0);

      // Reset pulse that lives entirely between edges must be ignored.
      @(negedge sysClk);
      applyStimulus(1'b1, 1'b0, SEL_IN_1, 1'b0);
      nextEdge();
      checkOutput("pre_pulse", {63'd0, regBus.out}, 64'd1);
      #2;
      sysRst = 1'b1;
      #2;
      checkOutput("async_pulse_hold", {63'd0, regBus.out}, 64'd1);
      sysRst = 1'b0;
      nextEdge();
      checkOutput("after_pulse_edge", {63'd0, regBus.out}, 64'd1);

      // Random run with a single-cycle reset dropped in the middle.
      for (int i = 0; i < 1000; i++) begin
         a = 1'($urandom_range(0, 1));
         b = 1'($urandom_range(0, 1));
         s = 1'($urandom_range(0, 1));
         r = (i == 500);
         @(negedge sysClk);
         applyStimulus(a, b, s, r);
         #1;
         checkOutput("rand_comb", {63'd0, combBus.out}, {63'd0, expComb});
         nextEdge();
         checkOutput(r ? "rand_mid_reset" : "rand_reg",
                     {63'd0, regBus.out}, {63'd0, expReg});
      end

      // Wide instance: select alternating, output lags by one edge.
      for (int i = 0; i < 8; i++) begin
         @(negedge sysClk);
         applyWide(8'hA5, 8'h3C, 1'(i % 2), 1'b0);
         nextEdge();
         checkOutput("wide_alt", {56'd0, wideBus.out}, {56'd0, expWide});
      end
      checkOutput("wide_last_3c", {56'd0, wideBus.out}, 64'h3C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
